// File: rtl/clkdiv_multi.sv
// -----------------------------------------------------------------------------
// clkdiv_multi
//
// Multi-channel clock divider. Every channel runs off the single refclk and
// produces a one-cycle clock-enable pulse (ce) and a roughly 50% duty divided
// square wave (clk_div). Both have period N refclk cycles. The outputs are
// plain registered data signals; nothing here gates or derives a clock.
//
// Each channel has a shadow configuration (divide N, start phase P) written
// via cfg_wr. A cfg_apply strobe copies every shadow into the active set and
// realigns all channels together, so channels with equal N and P stay
// cycle-for-cycle identical.
//
// Ports
//   refclk     in   1       sole clock, rising edge
//   rst        in   1       synchronous active-high reset
//   cfg_wr     in   1       write strobe for one channel's shadow config
//   cfg_ch     in   3       channel index for cfg_wr (>= NUM_CH is ignored)
//   cfg_div    in   DIV_W   divide ratio N (values below 2 are treated as 2)
//   cfg_phase  in   DIV_W   start phase P (values >= N are treated as N-1)
//   cfg_apply  in   1       copy shadow to active and realign all channels
//   ce         out  NUM_CH  per-channel one-cycle enable pulse, period N
//   clk_div    out  NUM_CH  per-channel divided square wave, period N
//   locked     out  1       all channels running aligned on the applied config
// -----------------------------------------------------------------------------
module clkdiv_multi #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int DEF_DIV     = 2
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_apply,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_div,
    output logic              locked
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    // A reset divide below 2 would be meaningless; treat it like a written N.
    localparam logic [DIV_W-1:0] DEF_N   = DIV_W'((DEF_DIV < 2) ? 2 : DEF_DIV);

    localparam int               SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ALIGN  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Configuration clamping, applied once at write time so the stored shadow
    // and active values are always directly usable.
    // -------------------------------------------------------------------------
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

    function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                     input logic [DIV_W-1:0] n);
        return (p >= n) ? (n - ONE) : p;
    endfunction

    // -------------------------------------------------------------------------
    // Alignment / settle FSM
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             locked_q;
    logic             running;

    // Counters only advance (and outputs only pulse) outside ALIGN.
    assign running = (state_q == ST_SETTLE) || (state_q == ST_LOCKED);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_ALIGN: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_d = settle_q + SET_W'(1);
                if (cfg_apply) begin
                    state_d = ST_ALIGN;
                end else if (settle_q == SET_LAST) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (cfg_apply) begin
                    state_d = ST_ALIGN;
                end
            end
            default: begin
                state_d  = ST_ALIGN;
                settle_d = '0;
            end
        endcase
    end

    // locked is registered from the next state so it tracks state_q exactly
    // and drops on the same edge that enters ALIGN.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= ST_ALIGN;
            settle_q <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign locked = locked_q;

    // -------------------------------------------------------------------------
    // Per-channel configuration, counter and output registers
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] sh_div_q,  sh_div_d;
        logic [DIV_W-1:0] sh_ph_q,   sh_ph_d;
        logic [DIV_W-1:0] act_div_q, act_div_d;
        logic [DIV_W-1:0] act_ph_q,  act_ph_d;
        logic [DIV_W-1:0] cnt_q,     cnt_d;
        logic             ce_q,      ce_d;
        logic             clk_q,     clk_d;

        logic             wr_hit;
        logic [DIV_W-1:0] wr_div;
        logic [DIV_W-1:0] wr_ph;
        logic [DIV_W-1:0] last_cnt;
        logic [DIV_W-1:0] half_cnt;

        always_comb begin
            // Out-of-range channel indices never match any gi.
            wr_hit = cfg_wr && (cfg_ch == 3'(gi));
            wr_div = clamp_div(cfg_div);
            wr_ph  = clamp_phase(cfg_phase, wr_div);

            // The write lands first, so a coincident apply picks it up.
            sh_div_d  = wr_hit ? wr_div : sh_div_q;
            sh_ph_d   = wr_hit ? wr_ph  : sh_ph_q;
            act_div_d = cfg_apply ? sh_div_d : act_div_q;
            act_ph_d  = cfg_apply ? sh_ph_d  : act_ph_q;

            last_cnt = act_div_q - ONE;
            // ceil(N/2) without the overflow N+1 would have at N = 2^DIV_W-1.
            half_cnt = (act_div_q >> 1) + {{(DIV_W-1){1'b0}}, act_div_q[0]};

            if (running) begin
                cnt_d = (cnt_q == last_cnt) ? '0 : (cnt_q + ONE);
            end else begin
                // ALIGN load takes the phase an apply in this same cycle
                // is installing, not the outgoing one.
                cnt_d = act_ph_d;
            end

            ce_d  = running && (cnt_q == last_cnt);
            clk_d = running && (cnt_q < half_cnt);
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                sh_div_q  <= DEF_N;
                sh_ph_q   <= '0;
                act_div_q <= DEF_N;
                act_ph_q  <= '0;
                cnt_q     <= '0;
                ce_q      <= 1'b0;
                clk_q     <= 1'b0;
            end else begin
                sh_div_q  <= sh_div_d;
                sh_ph_q   <= sh_ph_d;
                act_div_q <= act_div_d;
                act_ph_q  <= act_ph_d;
                cnt_q     <= cnt_d;
                ce_q      <= ce_d;
                clk_q     <= clk_d;
            end
        end

        assign ce[gi]      = ce_q;
        assign clk_div[gi] = clk_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_multi
//
// Directed bench for clkdiv_multi with default parameters (3 channels,
// 16-bit config, LOCK_CYCLES=16, DEF_DIV=2).
//
// Edge numbering: "k" counts edges after the ALIGN edge, i.e. the edge at
// which the FSM was sampled in ALIGN and every counter was loaded with P.
// At edge k a channel's counter was (P + k - 1) mod N, so ce is high after
// edge k when that equals N-1, clk_div is high when it is below ceil(N/2),
// and locked is high from k = 16 onward.
// -----------------------------------------------------------------------------
module tb_clkdiv_multi;

    localparam int NUM_CH   = 3;
    localparam int DIV_W    = 16;
    localparam int LOCK_CYC = 16;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_apply;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk_div;
    logic              locked;

    int checks = 0;
    int errors = 0;

    // Hand-set effective (already clamped) configuration expected per channel.
    int cur_n [NUM_CH];
    int cur_p [NUM_CH];

    clkdiv_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYC),
        .DEF_DIV     (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_apply (cfg_apply),
        .ce        (ce),
        .clk_div   (clk_div),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it before sampling.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    function automatic logic exp_ce(input int n, input int p, input int k);
        return ((p + k - 1) % n) == (n - 1);
    endfunction

    function automatic logic exp_clk(input int n, input int p, input int k);
        return ((p + k - 1) % n) < ((n + 1) / 2);
    endfunction

    task automatic set_cur(input int ch, input int n, input int p);
        cur_n[ch] = n;
        cur_p[ch] = p;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, " ce"},      32'(ce),      32'd0);
        check_val({tag, " clk_div"}, 32'(clk_div), 32'd0);
        check_val({tag, " locked"},  32'(locked),  32'd0);
    endtask

    // Run nk edges after an ALIGN edge and compare all outputs each edge.
    task automatic run_check(input string tag, input int nk);
        logic [NUM_CH-1:0] ce_e;
        logic [NUM_CH-1:0] clk_e;
        for (int k = 1; k <= nk; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                ce_e[c]  = exp_ce(cur_n[c], cur_p[c], k);
                clk_e[c] = exp_clk(cur_n[c], cur_p[c], k);
            end
            check_val($sformatf("%s ce k=%0d", tag, k),      32'(ce),      32'(ce_e));
            check_val($sformatf("%s clk_div k=%0d", tag, k), 32'(clk_div), 32'(clk_e));
            check_val($sformatf("%s locked k=%0d", tag, k),  32'(locked),  32'(k >= LOCK_CYC));
        end
        $display("run %s: %0d edges, ch N/P = %0d/%0d %0d/%0d %0d/%0d", tag, nk,
                 cur_n[0], cur_p[0], cur_n[1], cur_p[1], cur_n[2], cur_p[2]);
    endtask

    task automatic wr_cfg(input logic [2:0] ch, input int n, input int p);
        cfg_wr    = 1'b1;
        cfg_ch    = ch;
        cfg_div   = DIV_W'(n);
        cfg_phase = DIV_W'(p);
        step();
        cfg_wr    = 1'b0;
        $display("write ch=%0d N=%0d P=%0d", ch, n, p);
    endtask

    // Pulse cfg_apply (optionally with a coincident write), then step through
    // the ALIGN edge, which leaves ce/clk_div/locked all low.
    task automatic apply_cfg(input string tag, input logic wr, input logic [2:0] ch,
                             input int n, input int p);
        cfg_wr    = wr;
        cfg_ch    = ch;
        cfg_div   = DIV_W'(n);
        cfg_phase = DIV_W'(p);
        cfg_apply = 1'b1;
        step();
        cfg_wr    = 1'b0;
        cfg_apply = 1'b0;
        check_val({tag, " locked after apply"}, 32'(locked), 32'd0);
        step();
        check_idle({tag, " align"});
        $display("apply %s wr=%0b ch=%0d N=%0d P=%0d", tag, wr, ch, n, p);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_wr    = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_apply = 1'b0;
        for (int c = 0; c < NUM_CH; c++) set_cur(c, 2, 0);

        // Reset state and release: edge 0 is the ALIGN edge.
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("edge0");
        run_check("defaults", 20);

        // ch1 N=4 P=1: ce at k=3,7,11; clk_div[1] 1,0,0,1 repeating.
        wr_cfg(3'd1, 4, 1);
        set_cur(1, 4, 1);
        apply_cfg("ch1_div4", 1'b0, 3'd0, 0, 0);
        run_check("ch1_div4", 16);

        // Clamping: N=0 P=9 -> N=2 P=1; N=5 P=7 -> N=5 P=4.
        wr_cfg(3'd2, 0, 9);
        set_cur(2, 2, 1);
        apply_cfg("clamp_lo", 1'b0, 3'd0, 0, 0);
        run_check("clamp_lo", 8);
        wr_cfg(3'd2, 5, 7);
        set_cur(2, 5, 4);
        apply_cfg("clamp_p", 1'b0, 3'd0, 0, 0);
        run_check("clamp_p", 16);

        // Write coinciding with apply takes effect in that apply.
        set_cur(0, 3, 0);
        apply_cfg("wr_apply", 1'b1, 3'd0, 3, 0);
        run_check("wr_apply", 16);

        // Out-of-range channel writes change nothing.
        wr_cfg(3'd5, 9, 3);
        wr_cfg(3'd3, 6, 2);
        apply_cfg("bad_ch", 1'b0, 3'd0, 0, 0);
        run_check("bad_ch", 12);

        // Reset mid-operation while locked on N=7, with a write and apply
        // in the same cycle that must lose to reset.
        wr_cfg(3'd0, 7, 0);
        set_cur(0, 7, 0);
        apply_cfg("div7", 1'b0, 3'd0, 0, 0);
        run_check("div7", 17);
        rst       = 1'b1;
        cfg_wr    = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = DIV_W'(6);
        cfg_phase = DIV_W'(1);
        cfg_apply = 1'b1;
        step();
        check_idle("mid_rst");
        rst       = 1'b0;
        cfg_wr    = 1'b0;
        cfg_apply = 1'b0;
        step();
        check_idle("mid_rst edge0");
        for (int c = 0; c < NUM_CH; c++) set_cur(c, 2, 0);
        run_check("post_rst", 17);
        // Shadows were reset too, so a bare apply keeps the defaults.
        apply_cfg("shadow_rst", 1'b0, 3'd0, 0, 0);
        run_check("shadow_rst", 4);

        // Re-apply during SETTLE restarts the settle count.
        apply_cfg("settle_a", 1'b0, 3'd0, 0, 0);
        run_check("settle_a", 4);
        apply_cfg("settle_b", 1'b0, 3'd0, 0, 0);
        run_check("settle_b", 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
